// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator control sequencer.
package calc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP_SEL,
    S_LAUNCH,
    S_WAIT,
    S_RESULT,
    S_ERR
  } state_e;

  localparam logic [1:0] DISP_ZEROS  = 2'd0;
  localparam logic [1:0] DISP_OP     = 2'd1;
  localparam logic [1:0] DISP_RESULT = 2'd2;
  localparam logic [1:0] DISP_ERR    = 2'd3;

  localparam int NUM_OPS_DEF   = 8;
  localparam int LOGIC_OPS_DEF = 4;
  localparam int TIMEOUT_DEF   = 64;

endpackage

// File: rtl/conv_watchdog.sv
// Cycle counter bounding how long the sequencer waits for converter ready.
module conv_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  // Expires in the TIMEOUT-th counted cycle; the count holds there.
  assign expired = (cnt_q == W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator control sequencer: op select, BCD conversion handshake with
// watchdog, result latch and display image selection.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int NUM_OPS   = NUM_OPS_DEF,
  parameter int LOGIC_OPS = LOGIC_OPS_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_p,
  input  logic        down_p,
  input  logic        enter_p,
  input  logic        back_p,
  input  logic [7:0]  calc_result,
  input  logic        bcd_rdy,
  input  logic [15:0] bcd,
  output logic [2:0]  op,
  output logic        conv_start,
  output logic [11:0] conv_value,
  output logic [15:0] result_bcd,
  output logic [1:0]  disp_sel,
  output logic        busy
);

  localparam logic [2:0] OP_MAX = 3'(NUM_OPS - 1);

  // Logic-op results are 4 binary digits shown as if they were decimal.
  function automatic logic [11:0] bin_as_dec(input logic [3:0] r);
    return (r[3] ? 12'd1000 : 12'd0) + (r[2] ? 12'd100 : 12'd0)
         + (r[1] ? 12'd10 : 12'd0) + (r[0] ? 12'd1 : 12'd0);
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        conv_start_q, conv_start_d;
  logic [11:0] conv_value_q, conv_value_d;
  logic [15:0] result_bcd_q, result_bcd_d;
  logic [1:0]  disp_sel_q, disp_sel_d;
  logic        busy_q, busy_d;
  logic        wd_expired;

  conv_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == S_LAUNCH),
    .en      (state_q == S_WAIT),
    .expired (wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    conv_start_d = 1'b0;
    conv_value_d = conv_value_q;
    result_bcd_d = result_bcd_q;

    unique case (state_q)
      S_IDLE: begin
        if (back_p)                state_d = S_IDLE;
        else if (enter_p)          state_d = S_LAUNCH;
        else if (up_p || down_p)   state_d = S_OP_SEL;
      end
      S_OP_SEL: begin
        if (back_p)       state_d = S_RESULT;
        else if (enter_p) state_d = S_LAUNCH;
        else if (up_p)    op_d = (op_q == OP_MAX) ? 3'd0 : op_q + 3'd1;
        else if (down_p)  op_d = (op_q == 3'd0) ? OP_MAX : op_q - 3'd1;
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        // Ready in the final count cycle takes precedence over the timeout.
        if (bcd_rdy) begin
          result_bcd_d = bcd;
          state_d      = S_RESULT;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_RESULT: begin
        if (back_p)              state_d = S_IDLE;
        else if (enter_p)        state_d = S_LAUNCH;
        else if (up_p || down_p) state_d = S_OP_SEL;
      end
      S_ERR: begin
        if (back_p)       state_d = S_IDLE;
        else if (enter_p) state_d = S_LAUNCH;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) op_d = 3'd0;

    // Launch outputs are registered on the edge into LAUNCH so conv_start
    // is high exactly for the LAUNCH cycle and conv_value is already stable.
    if (state_d == S_LAUNCH) begin
      conv_start_d = 1'b1;
      conv_value_d = ({29'd0, op_q} < LOGIC_OPS) ? bin_as_dec(calc_result[3:0])
                                                 : {4'b0, calc_result};
    end

    unique case (state_d)
      S_IDLE:   disp_sel_d = DISP_ZEROS;
      S_RESULT: disp_sel_d = DISP_RESULT;
      S_ERR:    disp_sel_d = DISP_ERR;
      default:  disp_sel_d = DISP_OP;
    endcase
    busy_d = (state_d == S_LAUNCH) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= 3'd0;
      conv_start_q <= 1'b0;
      conv_value_q <= 12'd0;
      result_bcd_q <= 16'd0;
      disp_sel_q   <= DISP_ZEROS;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      conv_start_q <= conv_start_d;
      conv_value_q <= conv_value_d;
      result_bcd_q <= result_bcd_d;
      disp_sel_q   <= disp_sel_d;
      busy_q       <= busy_d;
    end
  end

  assign op         = op_q;
  assign conv_start = conv_start_q;
  assign conv_value = conv_value_q;
  assign result_bcd = result_bcd_q;
  assign disp_sel   = disp_sel_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed self-checking bench for calc_seq_ctrl.
module tb_calc_seq_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up_p = 1'b0, down_p = 1'b0, enter_p = 1'b0, back_p = 1'b0;
  logic [7:0]  calc_result = 8'd0;
  logic        bcd_rdy = 1'b0;
  logic [15:0] bcd = 16'd0;
  logic [2:0]  op;
  logic        conv_start;
  logic [11:0] conv_value;
  logic [15:0] result_bcd;
  logic [1:0]  disp_sel;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  int start_cnt = 0;

  calc_seq_ctrl dut (
    .clk(clk), .rst(rst), .up_p(up_p), .down_p(down_p), .enter_p(enter_p),
    .back_p(back_p), .calc_result(calc_result), .bcd_rdy(bcd_rdy), .bcd(bcd),
    .op(op), .conv_start(conv_start), .conv_value(conv_value),
    .result_bcd(result_bcd), .disp_sel(disp_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (conv_start === 1'b1) start_cnt++;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive the given pulses for one sampling edge.
  task automatic press(input logic u, input logic d, input logic e, input logic b);
    up_p = u; down_p = d; enter_p = e; back_p = b;
    step();
    up_p = 0; down_p = 0; enter_p = 0; back_p = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    n_chk++; if (op !== 3'd0) begin n_fail++; $display("FAIL reset_op: got %0d want 0", op); end
    n_chk++; if (conv_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", conv_start); end
    n_chk++; if (conv_value !== 12'd0) begin n_fail++; $display("FAIL reset_value: got %0d want 0", conv_value); end
    n_chk++; if (result_bcd !== 16'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result_bcd); end
    n_chk++; if (disp_sel !== 2'd0) begin n_fail++; $display("FAIL reset_disp: got %0d want 0", disp_sel); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_enter_idle();
    calc_result = 8'h0B;
    press(0, 0, 1, 0);
    // LAUNCH cycle
    n_chk++; if (conv_start !== 1'b1) begin n_fail++; $display("FAIL launch_start: got %b want 1", conv_start); end
    n_chk++; if (conv_value !== 12'd1011) begin n_fail++; $display("FAIL launch_value: got %0d want 1011", conv_value); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL launch_busy: got %b want 1", busy); end
    step();
    n_chk++; if (conv_start !== 1'b0) begin n_fail++; $display("FAIL start_one_cycle: got %b want 0", conv_start); end
    step(); step();
    bcd_rdy = 1'b1; bcd = 16'h1011;
    step();
    bcd_rdy = 1'b0;
    n_chk++; if (result_bcd !== 16'h1011) begin n_fail++; $display("FAIL idle_result: got %h want 1011", result_bcd); end
    n_chk++; if (disp_sel !== 2'd2) begin n_fail++; $display("FAIL idle_disp: got %0d want 2", disp_sel); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
    n_chk++; if (conv_value !== 12'd1011) begin n_fail++; $display("FAIL value_held: got %0d want 1011", conv_value); end
    n_chk++; if (start_cnt !== 1) begin n_fail++; $display("FAIL start_count: got %0d want 1", start_cnt); end
  endtask

  task automatic test_op_sel();
    press(1, 0, 0, 0);
    n_chk++; if (op !== 3'd0 || disp_sel !== 2'd1) begin n_fail++; $display("FAIL result_to_opsel: got op %0d disp %0d want 0/1", op, disp_sel); end
    for (int i = 0; i < 5; i++) press(1, 0, 0, 0);
    n_chk++; if (op !== 3'd5) begin n_fail++; $display("FAIL up_x5: got %0d want 5", op); end
    calc_result = 8'd200;
    press(0, 0, 1, 0);
    n_chk++; if (conv_value !== 12'd200) begin n_fail++; $display("FAIL arith_value: got %0d want 200", conv_value); end
    // Ready already high on WAIT entry: fastest path, RESULT two edges later.
    bcd_rdy = 1'b1; bcd = 16'h0200;
    step(); step();
    bcd_rdy = 1'b0;
    n_chk++; if (result_bcd !== 16'h0200 || disp_sel !== 2'd2) begin n_fail++; $display("FAIL fast_path: got %h disp %0d want 0200/2", result_bcd, disp_sel); end
    n_chk++; if (op !== 3'd5) begin n_fail++; $display("FAIL op_kept: got %0d want 5", op); end
  endtask

  task automatic test_wrap();
    press(0, 0, 0, 1);
    n_chk++; if (disp_sel !== 2'd0 || op !== 3'd0) begin n_fail++; $display("FAIL back_idle: got disp %0d op %0d want 0/0", disp_sel, op); end
    press(0, 1, 0, 0);
    n_chk++; if (op !== 3'd0 || disp_sel !== 2'd1) begin n_fail++; $display("FAIL idle_down: got op %0d disp %0d want 0/1", op, disp_sel); end
    press(0, 1, 0, 0);
    n_chk++; if (op !== 3'd7) begin n_fail++; $display("FAIL wrap_down: got %0d want 7", op); end
    press(1, 0, 0, 0);
    n_chk++; if (op !== 3'd0) begin n_fail++; $display("FAIL wrap_up: got %0d want 0", op); end
    press(1, 1, 0, 0);
    n_chk++; if (op !== 3'd1) begin n_fail++; $display("FAIL up_over_down: got %0d want 1", op); end
    press(0, 0, 1, 1);
    n_chk++; if (disp_sel !== 2'd2 || conv_start !== 1'b0) begin n_fail++; $display("FAIL back_over_enter: got disp %0d start %b want 2/0", disp_sel, conv_start); end
  endtask

  task automatic test_timeout();
    calc_result = 8'h05;
    press(0, 0, 1, 0);
    n_chk++; if (conv_value !== 12'd101) begin n_fail++; $display("FAIL logic_value: got %0d want 101", conv_value); end
    step();  // first WAIT cycle
    press(1, 0, 0, 0);
    repeat (TIMEOUT - 2) step();
    n_chk++; if (busy !== 1'b1 || disp_sel !== 2'd1 || op !== 3'd1) begin n_fail++; $display("FAIL wait_last: got busy %b disp %0d op %0d want 1/1/1", busy, disp_sel, op); end
    step();
    n_chk++; if (disp_sel !== 2'd3 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_err: got disp %0d busy %b want 3/0", disp_sel, busy); end
    n_chk++; if (result_bcd !== 16'h0200) begin n_fail++; $display("FAIL err_keep: got %h want 0200", result_bcd); end
    press(1, 0, 0, 0);
    n_chk++; if (disp_sel !== 2'd3) begin n_fail++; $display("FAIL err_ignore_up: got %0d want 3", disp_sel); end
    press(0, 0, 0, 1);
    n_chk++; if (disp_sel !== 2'd0 || op !== 3'd0) begin n_fail++; $display("FAIL err_back: got disp %0d op %0d want 0/0", disp_sel, op); end
    // Ready in the final count cycle beats the timeout.
    press(0, 0, 1, 0);
    step();
    repeat (TIMEOUT - 1) step();
    bcd_rdy = 1'b1; bcd = 16'h0101;
    step();
    bcd_rdy = 1'b0;
    n_chk++; if (disp_sel !== 2'd2 || result_bcd !== 16'h0101) begin n_fail++; $display("FAIL last_cycle_rdy: got disp %0d res %h want 2/0101", disp_sel, result_bcd); end
  endtask

  task automatic test_rst_in_wait();
    press(0, 0, 1, 0);
    step(); step();
    #2 rst = 1'b1;
    #1;
    n_chk++; if ({op, conv_start, conv_value, result_bcd, disp_sel, busy} !== 35'd0) begin n_fail++; $display("FAIL async_rst: got op %0d st %b val %0d res %h disp %0d busy %b want all 0", op, conv_start, conv_value, result_bcd, disp_sel, busy); end
    step();
    rst = 1'b0;
    bcd_rdy = 1'b1; bcd = 16'hFFFF;
    step(); step();
    bcd_rdy = 1'b0;
    n_chk++; if (result_bcd !== 16'd0 || disp_sel !== 2'd0 || busy !== 1'b0 || conv_start !== 1'b0 || conv_value !== 12'd0) begin n_fail++; $display("FAIL stale_rdy: got res %h disp %0d busy %b st %b val %0d want all 0", result_bcd, disp_sel, busy, conv_start, conv_value); end
  endtask

  task automatic test_back_to_back();
    int cnt0;
    calc_result = 8'h01;
    press(0, 0, 1, 0);
    bcd_rdy = 1'b1; bcd = 16'h0001;
    step(); step();
    bcd_rdy = 1'b0;
    n_chk++; if (disp_sel !== 2'd2 || result_bcd !== 16'h0001) begin n_fail++; $display("FAIL b2b_result: got disp %0d res %h want 2/0001", disp_sel, result_bcd); end
    cnt0 = start_cnt;
    press(0, 0, 1, 1);
    step();
    n_chk++; if (disp_sel !== 2'd0 || busy !== 1'b0 || start_cnt !== cnt0) begin n_fail++; $display("FAIL b2b_back: got disp %0d busy %b starts %0d want 0/0/%0d", disp_sel, busy, start_cnt, cnt0); end
  endtask

  initial begin
    test_reset();
    test_enter_idle();
    test_op_sel();
    test_wrap();
    test_timeout();
    test_rst_in_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
